// File: rtl/hyperbus_dev_phy.sv
// HyperBus device-side responder: decodes CA, applies initial latency, streams reads / accepts masked writes.
// Latency: read word popped on a ck-enabled cycle is on hyper_dq_o the next cycle; write push to mem_req_o is 1 cycle when empty.
// Backpressure: backend stalls show up as RWDS 2'b00 gap cycles; a full write buffer drops words and sets wr_overflow_o.
// Ports: clk_i/rst_i (async active-high); hyper_* word-level link (DDR pair packed in 16 bits);
//        mem_* request/grant backend with in-order rvalid; wr_overflow_o sticky drop flag; cfg_o config register.
module hyperbus_dev_phy #(
  parameter int          AddrWidth     = 32,
  parameter int          Latency       = 6,
  parameter int          DoubleLatency = 1,
  parameter int          RdFifoDepth   = 4,
  parameter int          WrFifoDepth   = 4,
  parameter int          WrapWords     = 16,
  parameter logic [15:0] IdReg         = 16'h0c81
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hyper_cs_ni,
  input  logic                 hyper_ck_ena_i,
  input  logic [15:0]          hyper_dq_i,
  input  logic [1:0]           hyper_rwds_i,
  output logic [15:0]          hyper_dq_o,
  output logic                 hyper_dq_oe_o,
  output logic [1:0]           hyper_rwds_o,
  output logic                 hyper_rwds_oe_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [15:0]          mem_wdata_o,
  output logic [1:0]           mem_be_o,
  input  logic                 mem_rvalid_i,
  input  logic [15:0]          mem_rdata_i,
  output logic                 wr_overflow_o,
  output logic [15:0]          cfg_o
);

  localparam int RP = $clog2(RdFifoDepth);
  localparam int WP = $clog2(WrFifoDepth);
  localparam int EW = AddrWidth + 18;  // write buffer entry {addr, data, be}
  localparam logic                 DL       = (DoubleLatency != 0);
  localparam logic [7:0]           LatInit  = 8'(DL ? 2 * Latency : Latency);
  localparam logic [RP:0]          RdDepth  = (RP+1)'(RdFifoDepth);
  localparam logic [WP:0]          WrDepth  = (WP+1)'(WrFifoDepth);
  localparam logic [AddrWidth-1:0] WrapMask = AddrWidth'(WrapWords - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CA    = 3'd1;
  localparam logic [2:0] S_LAT   = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_REGWR = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;  // register write done, waiting for CS high

  // Wrapped bursts only step the low log2(WrapWords) bits.
  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a, input logic lin);
    logic [AddrWidth-1:0] inc;
    inc = a + AddrWidth'(1);
    return lin ? inc : ((a & ~WrapMask) | (inc & WrapMask));
  endfunction

  logic [2:0]           state_q, state_d;
  logic [31:0]          ca_q, ca_d;
  logic                 ca_cnt_q, ca_cnt_d;
  logic                 is_rd_q, is_rd_d, is_reg_q, is_reg_d, is_lin_q, is_lin_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           lat_q, lat_d;
  logic [15:0]          dq_q, dq_d;
  logic                 dq_oe_q, dq_oe_d, rwds_oe_q, rwds_oe_d;
  logic [1:0]           rwds_q, rwds_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [AddrWidth-1:0] maddr_q, maddr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [1:0]           be_q, be_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          cfg_q, cfg_d;
  logic [RP:0]          out_q, out_d, disc_q, disc_d, rd_cnt_q, rd_cnt_d;
  logic [RP-1:0]        rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
  logic [WP:0]          wb_cnt_q, wb_cnt_d;
  logic [WP-1:0]        wb_wp_q, wb_wp_d, wb_rp_q, wb_rp_d;
  logic [15:0]          rd_mem_q [RdFifoDepth];
  logic [EW-1:0]        wb_mem_q [WrFifoDepth];

  logic          ck, w_vld, rd_want, slot, bypass, issue_rd, flush;
  logic          rd_push, rd_pop, wb_push, wb_pop;
  logic [EW-1:0] wb_head, wb_entry;

  always_comb begin
    state_d = state_q;  ca_d = ca_q;  ca_cnt_d = ca_cnt_q;
    is_rd_d = is_rd_q;  is_reg_d = is_reg_q;  is_lin_d = is_lin_q;
    addr_d = addr_q;  lat_d = lat_q;
    dq_d = dq_q;  dq_oe_d = dq_oe_q;  rwds_d = rwds_q;  rwds_oe_d = rwds_oe_q;
    req_d = req_q;  we_d = we_q;  maddr_d = maddr_q;  wdata_d = wdata_q;  be_d = be_q;
    ovf_d = ovf_q;  cfg_d = cfg_q;  disc_d = disc_q;
    rd_push = 1'b0;  rd_pop = 1'b0;  wb_push = 1'b0;  wb_pop = 1'b0;
    bypass = 1'b0;  issue_rd = 1'b0;  flush = 1'b0;

    ck       = hyper_ck_ena_i & ~hyper_cs_ni;
    w_vld    = (state_q == S_WR) & ck;
    wb_entry = {addr_q, hyper_dq_i, ~hyper_rwds_i};
    wb_head  = wb_mem_q[wb_rp_q];
    // Credit check: issued-but-unreturned reads (including stale ones) plus buffered words.
    rd_want  = ((state_q == S_LAT) | (state_q == S_RD)) & is_rd_q & ~is_reg_q & ~hyper_cs_ni &
               (({1'b0, out_q} + {1'b0, rd_cnt_q}) < {1'b0, RdDepth});

    // Backend request slot: buffered writes first, then a bypassed fresh write, then prefetch.
    slot = ~req_q | mem_gnt_i;
    if (slot) begin
      req_d = 1'b0;
      if (wb_cnt_q != '0) begin
        wb_pop = 1'b1;  req_d = 1'b1;  we_d = 1'b1;
        maddr_d = wb_head[EW-1:18];  wdata_d = wb_head[17:2];  be_d = wb_head[1:0];
      end else if (w_vld) begin
        bypass = 1'b1;  req_d = 1'b1;  we_d = 1'b1;
        maddr_d = addr_q;  wdata_d = hyper_dq_i;  be_d = ~hyper_rwds_i;
      end else if (rd_want) begin
        issue_rd = 1'b1;  req_d = 1'b1;  we_d = 1'b0;
        maddr_d = addr_q;  wdata_d = '0;  be_d = 2'b11;
        addr_d = next_addr(addr_q, is_lin_q);
      end
    end

    if (w_vld) begin
      addr_d = next_addr(addr_q, is_lin_q);
      if (!bypass) begin
        if ((wb_cnt_q != WrDepth) || wb_pop) wb_push = 1'b1;
        else ovf_d = 1'b1;
      end
    end

    // Returns belonging to an aborted burst are dropped first (rvalid is in order).
    if (mem_rvalid_i) begin
      if (disc_q != '0) disc_d = disc_q - (RP+1)'(1);
      else rd_push = 1'b1;
    end
    out_d = out_q + (RP+1)'(issue_rd) - (RP+1)'(mem_rvalid_i);

    case (state_q)
      S_IDLE: begin
        dq_oe_d = 1'b0;  dq_d = '0;
        rwds_oe_d = ~hyper_cs_ni;
        rwds_d = hyper_cs_ni ? 2'b00 : {2{DL}};
        if (!hyper_cs_ni && hyper_ck_ena_i) begin
          ca_d[31:16] = hyper_dq_i;  ca_cnt_d = 1'b0;  state_d = S_CA;
        end
      end
      S_CA: if (ck) begin
        if (!ca_cnt_q) begin
          ca_d[15:0] = hyper_dq_i;  ca_cnt_d = 1'b1;
        end else begin
          is_rd_d = ca_q[31];  is_reg_d = ca_q[30];  is_lin_d = ca_q[29];
          addr_d = AddrWidth'({ca_q[28:0], hyper_dq_i[2:0]});
          rwds_oe_d = 1'b0;  rwds_d = 2'b00;
          if (ca_q[30] && !ca_q[31]) state_d = S_REGWR;
          else begin
            lat_d = LatInit;  state_d = S_LAT;
          end
        end
      end
      S_LAT: if (ck) begin
        if (lat_q <= 8'd1) begin
          state_d = is_rd_q ? S_RD : S_WR;
          dq_oe_d = is_rd_q;  rwds_oe_d = is_rd_q;  rwds_d = 2'b00;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      S_RD: if (ck) begin
        if (is_reg_q) begin
          dq_d = (addr_q == '0) ? IdReg : cfg_q;  rwds_d = 2'b10;
          addr_d = next_addr(addr_q, is_lin_q);
        end else if (rd_cnt_q != '0) begin
          rd_pop = 1'b1;  dq_d = rd_mem_q[rd_rp_q];  rwds_d = 2'b10;
        end else begin
          rwds_d = 2'b00;  // stall gap
        end
      end
      S_REGWR: if (ck) begin
        cfg_d = hyper_dq_i;  state_d = S_WAIT;
      end
      default: ;
    endcase

    if (hyper_cs_ni && (state_q != S_IDLE)) begin
      state_d = S_IDLE;  dq_oe_d = 1'b0;  rwds_oe_d = 1'b0;  dq_d = '0;  rwds_d = 2'b00;
      flush = 1'b1;  disc_d = out_d;  // everything still in flight is now stale
    end

    rd_wp_d  = flush ? '0 : rd_wp_q + RP'(rd_push);
    rd_rp_d  = flush ? '0 : rd_rp_q + RP'(rd_pop);
    rd_cnt_d = flush ? '0 : rd_cnt_q + (RP+1)'(rd_push) - (RP+1)'(rd_pop);
    wb_wp_d  = wb_wp_q + WP'(wb_push);
    wb_rp_d  = wb_rp_q + WP'(wb_pop);
    wb_cnt_d = wb_cnt_q + (WP+1)'(wb_push) - (WP+1)'(wb_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rd_push) rd_mem_q[rd_wp_q] <= mem_rdata_i;
    if (wb_push) wb_mem_q[wb_wp_q] <= wb_entry;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;  ca_q <= '0;  ca_cnt_q <= 1'b0;
      is_rd_q <= 1'b0;  is_reg_q <= 1'b0;  is_lin_q <= 1'b0;
      addr_q <= '0;  lat_q <= '0;
      dq_q <= '0;  dq_oe_q <= 1'b0;  rwds_q <= '0;  rwds_oe_q <= 1'b0;
      req_q <= 1'b0;  we_q <= 1'b0;  maddr_q <= '0;  wdata_q <= '0;  be_q <= '0;
      ovf_q <= 1'b0;  cfg_q <= 16'h8f1f;
      out_q <= '0;  disc_q <= '0;  rd_cnt_q <= '0;  rd_wp_q <= '0;  rd_rp_q <= '0;
      wb_cnt_q <= '0;  wb_wp_q <= '0;  wb_rp_q <= '0;
    end else begin
      state_q <= state_d;  ca_q <= ca_d;  ca_cnt_q <= ca_cnt_d;
      is_rd_q <= is_rd_d;  is_reg_q <= is_reg_d;  is_lin_q <= is_lin_d;
      addr_q <= addr_d;  lat_q <= lat_d;
      dq_q <= dq_d;  dq_oe_q <= dq_oe_d;  rwds_q <= rwds_d;  rwds_oe_q <= rwds_oe_d;
      req_q <= req_d;  we_q <= we_d;  maddr_q <= maddr_d;  wdata_q <= wdata_d;  be_q <= be_d;
      ovf_q <= ovf_d;  cfg_q <= cfg_d;
      out_q <= out_d;  disc_q <= disc_d;  rd_cnt_q <= rd_cnt_d;  rd_wp_q <= rd_wp_d;  rd_rp_q <= rd_rp_d;
      wb_cnt_q <= wb_cnt_d;  wb_wp_q <= wb_wp_d;  wb_rp_q <= wb_rp_d;
    end
  end

  assign hyper_dq_o      = dq_q;
  assign hyper_dq_oe_o   = dq_oe_q;
  assign hyper_rwds_o    = rwds_q;
  assign hyper_rwds_oe_o = rwds_oe_q;
  assign mem_req_o       = req_q;
  assign mem_we_o        = we_q;
  assign mem_addr_o      = maddr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_be_o        = be_q;
  assign wr_overflow_o   = ovf_q;
  assign cfg_o           = cfg_q;

endmodule

// File: tb/tb_hyperbus_dev_phy.sv
// Testbench for hyperbus_dev_phy: directed link transactions against a behavioural backend.
// Host drives on the falling edge and samples outputs there; backend acts 1 time unit after the rising edge.
// Backend grant pattern and read return delay are switchable per test.
module tb_hyperbus_dev_phy;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n, ck_ena;
  logic [15:0] dq_i;
  logic [1:0]  rwds_i;
  logic [15:0] dq_o;
  logic        dq_oe, rwds_oe;
  logic [1:0]  rwds_o;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;
  logic        wr_ovf;
  logic [15:0] cfg;

  always #5 clk = ~clk;

  hyperbus_dev_phy dut (
    .clk_i(clk), .rst_i(rst),
    .hyper_cs_ni(cs_n), .hyper_ck_ena_i(ck_ena), .hyper_dq_i(dq_i), .hyper_rwds_i(rwds_i),
    .hyper_dq_o(dq_o), .hyper_dq_oe_o(dq_oe), .hyper_rwds_o(rwds_o), .hyper_rwds_oe_o(rwds_oe),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .wr_overflow_o(wr_ovf), .cfg_o(cfg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Backend memory contents.
  function automatic logic [15:0] bdata(input logic [31:0] a);
    return 16'hA500 ^ a[15:0];
  endfunction

  int          cyc = 0;
  int          gnt_mode = 0;  // 0 always, 1 every 3rd cycle, 2 never
  int          rd_lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] rd_log[$];
  logic [31:0] wl_addr[$];
  logic [15:0] wl_data[$];
  logic [1:0]  wl_be[$];

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mem_rvalid = 1'b0; mem_rdata = '0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = bdata(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      case (gnt_mode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = (cyc % 3 == 0);
        default: mem_gnt = 1'b0;
      endcase
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          wl_addr.push_back(mem_addr); wl_data.push_back(mem_wdata); wl_be.push_back(mem_be);
        end else begin
          pend_addr.push_back(mem_addr); pend_due.push_back(cyc + rd_lat); rd_log.push_back(mem_addr);
        end
      end
    end
  end

  // Host side: sample the previous cycle's outputs, then drive this cycle's inputs.
  logic [15:0] obs_dq;
  logic [1:0]  obs_rwds;
  logic        obs_dq_oe, obs_rwds_oe;
  logic        ca_rwds_oe, first_dq_oe;
  logic [1:0]  ca_rwds;
  logic [15:0] got[$];
  int          first_k, gaps;

  task automatic step(input logic c, input logic k, input logic [15:0] d, input logic [1:0] r);
    @(negedge clk);
    obs_dq = dq_o; obs_rwds = rwds_o; obs_dq_oe = dq_oe; obs_rwds_oe = rwds_oe;
    cs_n = c; ck_ena = k; dq_i = d; rwds_i = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 16'h0, 2'b00);
  endtask

  task automatic send_ca(input logic rd, input logic rs, input logic lin, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, rs, lin, a[31:3], 13'd0, a[2:0]};
    step(1'b0, 1'b1, ca[47:32], 2'b00);
    step(1'b0, 1'b1, ca[31:16], 2'b00);
    ca_rwds_oe = obs_rwds_oe; ca_rwds = obs_rwds;
    step(1'b0, 1'b1, ca[15:0], 2'b00);
  endtask

  task automatic do_read(input logic rs, input logic lin, input logic [31:0] a, input int n);
    got.delete(); first_k = 0; gaps = 0; first_dq_oe = 1'b0;
    send_ca(1'b1, rs, lin, a);
    for (int k = 1; k <= 300 && got.size() < n; k++) begin
      step(1'b0, 1'b1, 16'h0, 2'b00);
      if (obs_rwds_oe && obs_rwds == 2'b10) begin
        if (first_k == 0) begin first_k = k; first_dq_oe = obs_dq_oe; end
        got.push_back(obs_dq);
      end else if (first_k != 0 && obs_rwds_oe && obs_rwds == 2'b00) begin
        gaps++;
      end
    end
    idle(2);
  endtask

  task automatic do_write(input logic [31:0] a, input int n, input logic [15:0] base, input logic [5:0] masks);
    send_ca(1'b0, 1'b0, 1'b1, a);
    repeat (12) step(1'b0, 1'b1, 16'h0, 2'b00);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 16'(i), (i < 3) ? masks[2*i +: 2] : 2'b00);
    idle(2);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 60 && wl_addr.size() < n; i++) idle(1);
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; ck_ena = 1'b0; dq_i = '0; rwds_i = '0;
    repeat (3) @(negedge clk);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_rwds_oe", rwds_oe, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_ovf", wr_ovf, 0);
    check("rst_cfg", cfg, 16'h8f1f);
    check("rst_dq", dq_o, 0);
    rst = 1'b0;
    idle(3);

    // Linear read, zero-wait backend: 12 latency cycles, then back-to-back words.
    rd_log.delete();
    do_read(1'b0, 1'b1, 32'h100, 4);
    check("ca_rwds_oe", ca_rwds_oe, 1);
    check("ca_rwds", ca_rwds, 2'b11);
    check("rd_first_k", first_k, 14);
    check("rd_dq_oe", first_dq_oe, 1);
    check("rd_gaps", gaps, 0);
    check("rd_w0", got[0], 16'hA400);
    check("rd_w1", got[1], 16'hA401);
    check("rd_w2", got[2], 16'hA402);
    check("rd_w3", got[3], 16'hA403);
    check("rd_addr0", rd_log[0], 32'h100);
    check("rd_addr3", rd_log[3], 32'h103);

    // Stalling backend: gap cycles appear, order preserved.
    gnt_mode = 1;
    do_read(1'b0, 1'b1, 32'h200, 8);
    check("stall_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("stall_w%0d", i), got[i], 16'hA700 + 16'(i));
    check("stall_gaps", gaps != 0, 1);
    gnt_mode = 0;
    idle(6);

    // Wrapped read at 0x10E.
    rd_log.delete();
    do_read(1'b0, 1'b0, 32'h10E, 4);
    check("wrap_a0", rd_log[0], 32'h10E);
    check("wrap_a1", rd_log[1], 32'h10F);
    check("wrap_a2", rd_log[2], 32'h100);
    check("wrap_a3", rd_log[3], 32'h101);
    check("wrap_w2", got[2], 16'hA400);
    check("wrap_w3", got[3], 16'hA401);
    idle(6);

    // Masked write: rwds 00, 01, 11.
    wl_addr.delete(); wl_data.delete(); wl_be.delete();
    do_write(32'h20, 3, 16'h1110, {2'b11, 2'b01, 2'b00});
    wait_writes(3);
    check("wr_count", wl_addr.size(), 3);
    check("wr_a0", wl_addr[0], 32'h20);
    check("wr_a1", wl_addr[1], 32'h21);
    check("wr_a2", wl_addr[2], 32'h22);
    check("wr_be0", wl_be[0], 2'b11);
    check("wr_be1", wl_be[1], 2'b10);
    check("wr_be2", wl_be[2], 2'b00);
    check("wr_d1", wl_data[1], 16'h1111);
    check("wr_ovf_clear", wr_ovf, 0);

    // Register write, then register reads at 0 and 1.
    send_ca(1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b1, 16'h8f17, 2'b00);
    idle(2);
    check("cfg_written", cfg, 16'h8f17);
    rd_log.delete();
    do_read(1'b1, 1'b1, 32'h0, 1);
    check("reg_rd0", got[0], 16'h0c81);
    do_read(1'b1, 1'b1, 32'h1, 1);
    check("reg_rd1", got[0], 16'h8f17);
    check("reg_no_backend", rd_log.size(), 0);

    // Abort after 2 words with slow returns, then a fresh burst.
    rd_lat = 4;
    do_read(1'b0, 1'b1, 32'h300, 2);
    check("abort_w0", got[0], 16'hA600);
    check("abort_w1", got[1], 16'hA601);
    do_read(1'b0, 1'b1, 32'h400, 4);
    for (int i = 0; i < 4; i++) check($sformatf("after_abort_w%0d", i), got[i], 16'hA100 + 16'(i));
    rd_lat = 1;
    idle(10);

    // Write overflow with the backend never granting.
    wl_addr.delete(); wl_data.delete(); wl_be.delete();
    gnt_mode = 2;
    do_write(32'h40, 8, 16'h4000, 6'b0);
    check("ovf_set", wr_ovf, 1);
    gnt_mode = 0;
    wait_writes(2);
    idle(10);
    check("ovf_first_addr", wl_addr[0], 32'h40);
    check("ovf_first_data", wl_data[0], 16'h4000);
    check("ovf_sticky", wr_ovf, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
